// File: rtl/map_distributor.sv
// Round-robin distributor: deals one job's word stream across NUM_MAPPERS registered lanes.
// Optional per-lane handshake counters are built when MAP_DIST_LANE_COUNT_EN is defined.
module map_distributor #(
  parameter int unsigned NUM_MAPPERS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_LEN   = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic                              i_valid,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic [NUM_MAPPERS*DATA_WIDTH-1:0] o_mapper_data,
  output logic [NUM_MAPPERS-1:0]            o_mapper_valid,
  input  logic [NUM_MAPPERS-1:0]            i_mapper_ready,
  output logic                              o_done,
  output logic [31:0]                       o_word_count,
  output logic [NUM_MAPPERS*32-1:0]         o_lane_count
);

  localparam int unsigned PtrW   = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;
  localparam int unsigned BurstW = $clog2(BURST_LEN + 1);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(NUM_MAPPERS - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_LEN - 1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e                            state_q, state_d;
  logic [PtrW-1:0]                   ptr_q, ptr_d;
  logic [BurstW-1:0]                 burst_cnt_q, burst_cnt_d;
  logic [31:0]                       job_cnt_q, job_cnt_d;
  logic [NUM_MAPPERS*DATA_WIDTH-1:0] lane_data_q, lane_data_d;
  logic [NUM_MAPPERS-1:0]            lane_valid_q, lane_valid_d;
  logic                              done_q, done_d;
  logic [31:0]                       word_count_q, word_count_d;
  logic                              accept;
  logic                              job_end;

  // Ready depends only on registered state, never on the mapper ready inputs.
  assign o_ready = (state_q == StRun) && !lane_valid_q[ptr_q];
  assign accept  = i_valid && o_ready;
  assign job_end = (state_q == StDrain) && (lane_valid_q == '0);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    burst_cnt_d  = burst_cnt_q;
    job_cnt_d    = job_cnt_q;
    lane_data_d  = lane_data_q;
    lane_valid_d = lane_valid_q & ~i_mapper_ready;
    done_d       = 1'b0;
    word_count_d = word_count_q;

    if (accept) begin
      lane_data_d[ptr_q*DATA_WIDTH +: DATA_WIDTH] = i_data;
      lane_valid_d[ptr_q] = 1'b1;
      job_cnt_d = job_cnt_q + 32'd1;
      if (burst_cnt_q == BurstLast) begin
        burst_cnt_d = '0;
        ptr_d       = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
      end else begin
        burst_cnt_d = burst_cnt_q + BurstW'(1);
      end
      if (i_last) begin
        state_d = StDrain;
      end
    end

    if (job_end) begin
      done_d       = 1'b1;
      word_count_d = job_cnt_q;
      job_cnt_d    = '0;
      ptr_d        = '0;
      burst_cnt_d  = '0;
      state_d      = StRun;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StRun;
      ptr_q        <= '0;
      burst_cnt_q  <= '0;
      job_cnt_q    <= '0;
      lane_data_q  <= '0;
      lane_valid_q <= '0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      job_cnt_q    <= job_cnt_d;
      lane_data_q  <= lane_data_d;
      lane_valid_q <= lane_valid_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign o_mapper_data  = lane_data_q;
  assign o_mapper_valid = lane_valid_q;
  assign o_done         = done_q;
  assign o_word_count   = word_count_q;

`ifdef MAP_DIST_LANE_COUNT_EN
  logic [NUM_MAPPERS*32-1:0] lane_cnt_q, lane_cnt_d;
  logic [NUM_MAPPERS*32-1:0] lane_count_q, lane_count_d;

  // Lanes are all empty at job end, so no handshake can race the snapshot.
  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    lane_count_d = lane_count_q;
    for (int unsigned k = 0; k < NUM_MAPPERS; k++) begin
      if (lane_valid_q[k] && i_mapper_ready[k]) begin
        lane_cnt_d[k*32 +: 32] = lane_cnt_q[k*32 +: 32] + 32'd1;
      end
    end
    if (job_end) begin
      lane_count_d = lane_cnt_q;
      lane_cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_cnt_q   <= '0;
      lane_count_q <= '0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      lane_count_q <= lane_count_d;
    end
  end

  assign o_lane_count = lane_count_q;
`else
  assign o_lane_count = '0;
`endif

endmodule

// File: tb/tb_map_distributor.sv
// Directed bench for map_distributor: dut1 uses BURST_LEN=1, dut2 uses BURST_LEN=2.
module tb_map_distributor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  d1, d2;
  logic         v1, v2, l1, l2;
  logic         rdy1, rdy2;
  logic [127:0] md1, md2;
  logic [3:0]   mv1, mv2;
  logic [3:0]   mr1, mr2;
  logic         done1, done2;
  logic [31:0]  wc1, wc2;
  logic [127:0] lc1, lc2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got1 [4][64];
  logic [31:0] got2 [4][64];
  int          gcnt1 [4];
  int          gcnt2 [4];
  int          dcnt1 = 0;
  int          dcnt2 = 0;
  int          last_wait1;
  time         tacc2;

  always #5 clk = ~clk;

  map_distributor #(.NUM_MAPPERS(4), .DATA_WIDTH(32), .BURST_LEN(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_valid(v1), .i_last(l1),
    .o_ready(rdy1), .o_mapper_data(md1), .o_mapper_valid(mv1), .i_mapper_ready(mr1),
    .o_done(done1), .o_word_count(wc1), .o_lane_count(lc1)
  );

  map_distributor #(.NUM_MAPPERS(4), .DATA_WIDTH(32), .BURST_LEN(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d2), .i_valid(v2), .i_last(l2),
    .o_ready(rdy2), .o_mapper_data(md2), .o_mapper_valid(mv2), .i_mapper_ready(mr2),
    .o_done(done2), .o_word_count(wc2), .o_lane_count(lc2)
  );

  // Log every lane handshake and done pulse as seen at the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mv1[k] && mr1[k]) begin
        got1[k][gcnt1[k] % 64] <= md1[k*32 +: 32];
        gcnt1[k] <= gcnt1[k] + 1;
      end
      if (mv2[k] && mr2[k]) begin
        got2[k][gcnt2[k] % 64] <= md2[k*32 +: 32];
        gcnt2[k] <= gcnt2[k] + 1;
      end
    end
    if (done1) dcnt1 <= dcnt1 + 1;
    if (done2) dcnt2 <= dcnt2 + 1;
  end

  task automatic send1(input logic [31:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    v1 = 1'b1; d1 = d; l1 = last;
    while (!rdy1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    last_wait1 = t;
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL send1_timeout word %h not accepted after %0d cycles", d, t);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic send2(input logic [31:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    v2 = 1'b1; d2 = d; l2 = last;
    while (!rdy2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL send2_timeout word %h not accepted after %0d cycles", d, t);
    end
    @(posedge clk);
    tacc2 = $time;
    #1;
    v2 = 1'b0; l2 = 1'b0;
  endtask

  task automatic wait_done1(input int prev);
    int t = 0;
    while (dcnt1 == prev && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (dcnt1 == prev) begin
      n_fail++;
      $display("FAIL done1_timeout no done pulse within %0d cycles", t);
    end
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (mv1 !== 4'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0000", mv1); end
    if (md1 !== 128'b0) begin n_fail++; $display("FAIL reset_data got %h want 0", md1); end
    if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done1); end
    if (wc1 !== 32'd0) begin n_fail++; $display("FAIL reset_wc got %0d want 0", wc1); end
    if (lc1 !== 128'b0) begin n_fail++; $display("FAIL reset_lc got %h want 0", lc1); end
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy1); end
  endtask

  task automatic test_round_robin();
    int b[4];
    int d0 = dcnt1;
    for (int k = 0; k < 4; k++) b[k] = gcnt1[k];
    for (int i = 0; i < 8; i++) begin
      send1(32'(i + 1), i == 7);
      n_checks++;
      if (last_wait1 != 0) begin
        n_fail++;
        $display("FAIL rr_ready word %0d stalled %0d cycles want 0", i + 1, last_wait1);
      end
    end
    wait_done1(d0);
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (dcnt1 - d0 != 1) begin n_fail++; $display("FAIL rr_done_pulses got %0d want 1", dcnt1 - d0); end
    if (wc1 !== 32'd8) begin n_fail++; $display("FAIL rr_word_count got %0d want 8", wc1); end
    for (int k = 0; k < 4; k++) begin
      n_checks += 3;
      if (gcnt1[k] - b[k] != 2) begin
        n_fail++; $display("FAIL rr_lane%0d_count got %0d want 2", k, gcnt1[k] - b[k]);
      end
      if (got1[k][b[k] % 64] !== 32'(k + 1)) begin
        n_fail++; $display("FAIL rr_lane%0d_w0 got %0d want %0d", k, got1[k][b[k] % 64], k + 1);
      end
      if (got1[k][(b[k] + 1) % 64] !== 32'(k + 5)) begin
        n_fail++; $display("FAIL rr_lane%0d_w1 got %0d want %0d", k, got1[k][(b[k] + 1) % 64], k + 5);
      end
    end
  endtask

  task automatic test_burst();
    int  b[4];
    time t[8];
    time want;
    int  d0 = dcnt2;
    for (int k = 0; k < 4; k++) b[k] = gcnt2[k];
    for (int i = 0; i < 8; i++) begin
      send2(32'hA0 + 32'(i), i == 7);
      t[i] = tacc2;
    end
    for (int i = 1; i < 8; i++) begin
      want = (i % 2 == 1) ? 20 : 10;
      n_checks++;
      if (t[i] - t[i-1] != want) begin
        n_fail++; $display("FAIL burst_gap word %0d got %0t want %0t", i, t[i] - t[i-1], want);
      end
    end
    repeat (10) @(negedge clk);
    n_checks += 2;
    if (dcnt2 - d0 != 1) begin n_fail++; $display("FAIL burst_done got %0d want 1", dcnt2 - d0); end
    if (wc2 !== 32'd8) begin n_fail++; $display("FAIL burst_word_count got %0d want 8", wc2); end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (got2[k][(b[k] + j) % 64] !== 32'hA0 + 32'(2*k + j)) begin
          n_fail++;
          $display("FAIL burst_lane%0d_w%0d got %h want %h", k, j, got2[k][(b[k] + j) % 64],
                   32'hA0 + 32'(2*k + j));
        end
      end
    end
  endtask

  task automatic test_stall();
    int b[4];
    int d0 = dcnt1;
    for (int k = 0; k < 4; k++) b[k] = gcnt1[k];
    mr1 = 4'b1101;
    fork
      begin
        for (int i = 0; i < 10; i++) send1(32'h100 + 32'(i), i == 9);
      end
      begin
        repeat (20) @(negedge clk);
        n_checks += 4;
        if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", rdy1); end
        if (mv1[1] !== 1'b1) begin n_fail++; $display("FAIL stall_valid1 got %b want 1", mv1[1]); end
        if (md1[63:32] !== 32'h101) begin
          n_fail++; $display("FAIL stall_hold got %h want 101", md1[63:32]);
        end
        if (dcnt1 != d0) begin n_fail++; $display("FAIL stall_early_done got %0d want 0", dcnt1 - d0); end
        mr1 = 4'b1111;
      end
    join
    wait_done1(d0);
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (dcnt1 - d0 != 1) begin n_fail++; $display("FAIL stall_done got %0d want 1", dcnt1 - d0); end
    if (wc1 !== 32'd10) begin n_fail++; $display("FAIL stall_word_count got %0d want 10", wc1); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (gcnt1[k] - b[k] != ((k < 2) ? 3 : 2)) begin
        n_fail++; $display("FAIL stall_lane%0d_count got %0d want %0d", k, gcnt1[k] - b[k], (k < 2) ? 3 : 2);
      end
      for (int j = 0; j < ((k < 2) ? 3 : 2); j++) begin
        n_checks++;
        if (got1[k][(b[k] + j) % 64] !== 32'h100 + 32'(k + 4*j)) begin
          n_fail++;
          $display("FAIL stall_lane%0d_w%0d got %h want %h", k, j, got1[k][(b[k] + j) % 64],
                   32'h100 + 32'(k + 4*j));
        end
      end
    end
  endtask

  task automatic test_single();
    int b0;
    int d0;
    @(negedge clk);
    n_checks++;
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", rdy1); end
    v1 = 1'b1; d1 = 32'h55; l1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0;
    n_checks += 2;
    if (mv1 !== 4'b0001 || md1[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL single_lane0 got valid %b data %h want 0001 55", mv1, md1[31:0]);
    end
    if (done1 !== 1'b0) begin n_fail++; $display("FAIL single_done_e0 got %b want 0", done1); end
    @(posedge clk); #1;
    n_checks++;
    if (done1 !== 1'b0) begin n_fail++; $display("FAIL single_done_e1 got %b want 0", done1); end
    @(posedge clk); #1;
    n_checks += 2;
    if (done1 !== 1'b1) begin n_fail++; $display("FAIL single_done_e2 got %b want 1", done1); end
    if (wc1 !== 32'd1) begin n_fail++; $display("FAIL single_word_count got %0d want 1", wc1); end
    @(posedge clk); #1;
    n_checks++;
    if (done1 !== 1'b0) begin n_fail++; $display("FAIL single_done_e3 got %b want 0", done1); end
    b0 = gcnt1[0];
    d0 = dcnt1;
    send1(32'h66, 1'b1);
    wait_done1(d0);
    n_checks += 2;
    if (gcnt1[0] != b0 + 1 || got1[0][b0 % 64] !== 32'h66) begin
      n_fail++; $display("FAIL single_next_lane0 got count %0d data %h want 1 66", gcnt1[0] - b0,
                          got1[0][b0 % 64]);
    end
    if (wc1 !== 32'd1) begin n_fail++; $display("FAIL single_next_wc got %0d want 1", wc1); end
  endtask

  task automatic test_reset_mid();
    int b0;
    int d0;
    mr1 = 4'b0000;
    for (int i = 0; i < 3; i++) send1(32'h201 + 32'(i), 1'b0);
    @(negedge clk);
    n_checks++;
    if (mv1 !== 4'b0111) begin n_fail++; $display("FAIL rstmid_full got %b want 0111", mv1); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (mv1 !== 4'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0000", mv1); end
    if (md1 !== 128'b0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", md1); end
    if (wc1 !== 32'd0) begin n_fail++; $display("FAIL rstmid_wc got %0d want 0", wc1); end
    @(negedge clk);
    rst_n = 1'b1;
    mr1 = 4'b1111;
    b0 = gcnt1[0];
    d0 = dcnt1;
    send1(32'h77, 1'b1);
    wait_done1(d0);
    n_checks += 2;
    if (gcnt1[0] != b0 + 1 || got1[0][b0 % 64] !== 32'h77) begin
      n_fail++; $display("FAIL rstmid_lane0 got count %0d data %h want 1 77", gcnt1[0] - b0,
                          got1[0][b0 % 64]);
    end
    if (wc1 !== 32'd1) begin n_fail++; $display("FAIL rstmid_next_wc got %0d want 1", wc1); end
  endtask

  task automatic test_lane_count();
    logic [31:0] exp_lc [4];
    int d0 = dcnt1;
`ifdef MAP_DIST_LANE_COUNT_EN
    exp_lc = '{32'd2, 32'd2, 32'd1, 32'd1};
`else
    exp_lc = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 6; i++) send1(32'h300 + 32'(i), i == 5);
    wait_done1(d0);
    n_checks++;
    if (wc1 !== 32'd6) begin n_fail++; $display("FAIL lc_word_count got %0d want 6", wc1); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (lc1[k*32 +: 32] !== exp_lc[k]) begin
        n_fail++; $display("FAIL lc_lane%0d got %0d want %0d", k, lc1[k*32 +: 32], exp_lc[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; d1 = '0; l1 = 1'b0; mr1 = 4'b1111;
    v2 = 1'b0; d2 = '0; l2 = 1'b0; mr2 = 4'b1111;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_single();
    test_reset_mid();
    test_lane_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
